nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit adder that feeds one 4-bit nibble per clock into a single 4-bit ripple-carry adder stage and collects its sum and carry. It accepts operands over a valid/ready handshake and presents the full result over a second valid/ready handshake. It gives wide additions a small, fixed-area datapath and sits directly upstream and downstream of the 4-bit adder stage.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4; N = WIDTH/4 nibbles
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- out_valid  output  1  sum and cout are valid; high only in DONE
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  registered result, a + b + cin mod 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1

Clock and reset (already decided): one clock; reset is asynchronous and active-high.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid & in_ready: latch a→opA, b→opB, cin→carry; clear the nibble index; go to RUN.
- **RUN:** each cycle feeds opA[3:0], opB[3:0] and carry into the 4-bit adder.
  - The adder's 4-bit sum is shifted into the sum register from the MSB end: sum ← {nib_sum, sum[WIDTH-1:4]}.
  - carry ← adder carry-out.
  - opA and opB shift right by 4.
  - The index increments.
  - On nibble N-1: also load cout ← adder carry-out and go to DONE.
- **DONE:**
  - out_valid = 1; sum and cout are held stable.
  - On out_ready: go to IDLE.
  - sum and cout keep their values in IDLE until the next RUN begins overwriting them.
- **Ignored inputs:** in_valid is ignored outside IDLE, and out_ready is ignored outside DONE.
- **Arithmetic:** pure unsigned; no overflow flag. cout is the only width extension.
- **Reset:** assertion at any time, including mid-RUN or DONE, immediately forces state = IDLE and clears opA, opB, carry, index, sum and cout to 0. The partial result is discarded.
- **Reset values:** in_ready = 1, out_valid = 0, sum = 0, cout = 0.

## Timing
- **Accept:** operands are accepted on clock edge E0, where in_valid & in_ready are both high.
- **Nibble processing:** edges E1..EN process nibbles 0..N-1.
- **Result:** out_valid rises in the cycle after EN, giving a latency of N cycles from the accept edge (4 for WIDTH = 16).
- **Output handshake:** completes on the first edge where out_valid & out_ready are both high. in_ready is high in the following cycle.
- **Throughput:** with out_ready held high and in_valid held high, one operation every N+2 cycles.
- **Output handshake signals:** in_ready and out_valid are decoded from the state register only. They have no combinational path from in_valid or out_ready.
- **Adder path:** the 4-bit adder path is purely combinational within one RUN cycle. Its result is registered at the end of that cycle.

## Structure
- **Shared package:** holds the state enum (IDLE, RUN, DONE) and the constant NIBBLE_W = 4.
- **Sub-module:** exactly one natural instance, the existing ripplecarry_4b, fed from opA[3:0], opB[3:0] and carry.
- **Top level:** everything else (FSM, shift registers, index counter of width clog2(N), with a minimum of 1) lives in nibble_serial_adder.

## Test plan
- **Basic add:** WIDTH = 16, a = 0x1234, b = 0x4321, cin = 0. Required: sum = 0x5555, cout = 0; out_valid rises exactly 4 cycles after the accept edge.
- **Carry ripple:** a = 0xFFFF, b = 0x0001, cin = 0. Required: sum = 0x0000, cout = 1, with the carry propagated across all nibble boundaries. Then a = 0xFFFF, b = 0xFFFF, cin = 1. Required: sum = 0xFFFF, cout = 1.
- **Backpressure:**
  - a = 0x00F0, b = 0x0010; out_ready held low for 3 cycles after out_valid. Required: sum = 0x0100 held stable and in_ready = 0 throughout.
  - New in_valid with a = 0x1111 pulsed during RUN. Required: ignored; the result stays 0x0100.
- **Reset mid-operation:** assert rst after 2 RUN cycles. Required: immediately out_valid = 0, sum = 0, cout = 0, in_ready = 1. A following op with a = 0x0003, b = 0x0004 must give sum = 0x0007.
- **Back-to-back:** in_valid and out_ready held high across three ops: 0x0001 + 0x0001, 0x8000 + 0x8000, 0x7FFF + 0x0001. Required: results 0x0002/0, 0x0000/1, 0x8000/0, with out_valid pulses spaced exactly 6 cycles apart.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder and its 4-bit stage.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : nibble_serial_adder_pkg

// File: rtl/nibble_serial_adder_ripplecarry_4b.sv
// Purely combinational 4-bit ripple-carry adder stage.
module ripplecarry_4b (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    // Separate scalar carries keep the ripple chain free of a self-referencing vector.
    logic w_c1;
    logic w_c2;
    logic w_c3;

    assign o_sum[0] = i_a[0] ^ i_b[0] ^ i_cin;
    assign w_c1     = (i_a[0] & i_b[0]) | (i_cin & (i_a[0] ^ i_b[0]));
    assign o_sum[1] = i_a[1] ^ i_b[1] ^ w_c1;
    assign w_c2     = (i_a[1] & i_b[1]) | (w_c1 & (i_a[1] ^ i_b[1]));
    assign o_sum[2] = i_a[2] ^ i_b[2] ^ w_c2;
    assign w_c3     = (i_a[2] & i_b[2]) | (w_c2 & (i_a[2] ^ i_b[2]));
    assign o_sum[3] = i_a[3] ^ i_b[3] ^ w_c3;
    assign o_cout   = (i_a[3] & i_b[3]) | (w_c3 & (i_a[3] ^ i_b[3]));

endmodule : ripplecarry_4b

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams one nibble per clock through a single 4-bit
// ripple-carry stage, with valid/ready handshakes on operands and result.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic                      w_accept;
    logic                      w_run;
    logic                      w_last;
    logic [NIBBLE_W-1:0]       w_nib_sum;
    logic                      w_nib_cout;
    logic [WIDTH+NIBBLE_W-1:0] w_sum_cat;

    ripplecarry_4b u_rca (
        .i_a    (r_op_a[NIBBLE_W-1:0]),
        .i_b    (r_op_b[NIBBLE_W-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    assign w_last    = (r_idx == IDX_W'(N - 1));
    // New nibble enters at the MSB end; the slice also works when WIDTH == 4.
    assign w_sum_cat = {w_nib_sum, r_sum};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_run        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_op_a  <= a;
            r_op_b  <= b;
            r_carry <= cin;
            r_idx   <= '0;
        end else if (w_run) begin
            r_op_a  <= r_op_a >> NIBBLE_W;
            r_op_b  <= r_op_b >> NIBBLE_W;
            r_carry <= w_nib_cout;
            r_idx   <= r_idx + IDX_W'(1);
            r_sum   <= w_sum_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
            if (w_last) begin
                r_cout <= w_nib_cout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences
// and randomized operations against a plain-arithmetic reference.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             vcin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
    } vec_t;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one operation; optionally pulses a stray in_valid during RUN and
    // stalls out_ready for hold_cycles once the result is presented.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b,
                          input logic tcin, input int hold_cycles, input bit stray,
                          output logic [WIDTH-1:0] rs, output logic rc);
        int waited;
        int lat;
        @(negedge clk);
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_b;
        cin      = tcin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        if (stray) begin
            a        = 16'h1111;
            in_valid = 1'b1;
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
        end
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        rs = sum;
        rc = cout;
        for (int i = 0; i < hold_cycles; i++) begin
            check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " hold sum"}, 32'(sum), 32'(rs));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
        check({tag, " sum kept in idle"}, 32'(sum), 32'(rs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             vecs[5];
        logic [WIDTH-1:0] rs;
        logic             rc;
        logic [WIDTH:0]   model;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rcin;
        int               k;
        int               nres;
        int               res_cyc[3];
        logic [WIDTH-1:0] res_sum[3];
        logic             res_cout[3];
        logic [WIDTH-1:0] bb_a[3];
        logic [WIDTH-1:0] bb_b[3];
        bit               acc_last;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vcin, 0, 1'b0, rs, rc);
            check($sformatf("vec%0d sum", i), 32'(rs), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d cout", i), 32'(rc), 32'(vecs[i].exp_cout));
        end

        run_op("backpressure", 16'h00F0, 16'h0010, 1'b0, 3, 1'b1, rs, rc);
        check("backpressure sum", 32'(rs), 32'h0100);
        check("backpressure cout", 32'(rc), 32'd0);

        // Reset two RUN cycles into an operation.
        @(negedge clk);
        a        = 16'hABCD;
        b        = 16'h1234;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun reset out_valid", 32'(out_valid), 32'd0);
        check("midrun reset in_ready", 32'(in_ready), 32'd1);
        check("midrun reset sum", 32'(sum), 32'd0);
        check("midrun reset cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after reset", 16'h0003, 16'h0004, 1'b0, 0, 1'b0, rs, rc);
        check("after reset sum", 32'(rs), 32'h0007);
        check("after reset cout", 32'(rc), 32'd0);

        // Back-to-back with both handshakes held open.
        bb_a = '{16'h0001, 16'h8000, 16'h7FFF};
        bb_b = '{16'h0001, 16'h8000, 16'h0001};
        @(negedge clk);
        out_ready = 1'b1;
        cin       = 1'b0;
        a         = bb_a[0];
        b         = bb_b[0];
        in_valid  = 1'b1;
        acc_last  = in_ready;
        k         = 0;
        nres      = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (out_valid && nres < 3) begin
                res_cyc[nres]  = cyc;
                res_sum[nres]  = sum;
                res_cout[nres] = cout;
                nres++;
            end
            if (acc_last) begin
                k++;
                if (k < 3) begin
                    a = bb_a[k];
                    b = bb_b[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
            acc_last = in_ready && in_valid;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b result count", 32'(nres), 32'd3);
        if (nres == 3) begin
            check("b2b sum0", 32'(res_sum[0]), 32'h0002);
            check("b2b cout0", 32'(res_cout[0]), 32'd0);
            check("b2b sum1", 32'(res_sum[1]), 32'h0000);
            check("b2b cout1", 32'(res_cout[1]), 32'd1);
            check("b2b sum2", 32'(res_sum[2]), 32'h8000);
            check("b2b cout2", 32'(res_cout[2]), 32'd0);
            check("b2b spacing01", 32'(res_cyc[1] - res_cyc[0]), 32'd6);
            check("b2b spacing12", 32'(res_cyc[2] - res_cyc[1]), 32'd6);
        end

        for (int i = 0; i < 24; i++) begin
            ra    = WIDTH'($urandom);
            rb    = WIDTH'($urandom);
            rcin  = 1'($urandom_range(0, 1));
            model = {1'b0, ra} + {1'b0, rb} + (WIDTH + 1)'(rcin);
            run_op($sformatf("rand%0d", i), ra, rb, rcin, $urandom_range(0, 3), 1'b0, rs, rc);
            check($sformatf("rand%0d sum", i), 32'(rs), 32'(model[WIDTH-1:0]));
            check($sformatf("rand%0d cout", i), 32'(rc), 32'(model[WIDTH]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nibble_serial_adder
